// File: rtl/conv_encode_param.sv
// conv_encode_param
//   Frame-based rate-1/N_OUT feed-forward convolutional encoder with
//   constraint length K and generator polynomials supplied by parameter.
//   Each accepted information bit yields one N_OUT-bit symbol. When
//   TAIL_EN is set, K-1 zero bits are flushed after the last bit of a frame
//   so that every frame ends with the encoder back in state 0.
//
//   Ports
//     clk_sig    in   1      clock, rising edge
//     reset_sig  in   1      synchronous reset, active-low
//     in_bit     in   1      information bit
//     in_valid   in   1      in_bit valid
//     in_last    in   1      in_bit is the last bit of the frame
//     in_ready   out  1      encoder accepts in_bit this cycle
//     out_sym    out  N_OUT  encoded symbol; bit j uses GEN[j*K +: K]
//     out_valid  out  1      out_sym valid
//     out_last   out  1      out_sym is the last symbol of the frame
//     out_ready  in   1      downstream accepts out_sym
//     busy       out  1      tail flush in progress
module conv_encode_param #(
    parameter int                   N_OUT   = 2,
    parameter int                   K       = 3,
    parameter logic [N_OUT*K-1:0]   GEN     = {3'b111, 3'b101},
    parameter bit                   TAIL_EN = 1'b1
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [N_OUT-1:0] out_sym,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int             CW        = $clog2(K);
    localparam logic [CW-1:0]  TAIL_INIT = CW'(K - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    typedef enum logic {
        RUN  = 1'b0,
        TAIL = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [K-2:0]       sr_reg,    sr_next;     // sr_reg[K-2] = most recent past bit
    logic [CW-1:0]      cnt_reg,   cnt_next;
    logic [N_OUT-1:0]   sym_reg,   sym_next;
    logic               valid_reg, valid_next;
    logic               last_reg,  last_next;

    logic               slot_free;
    logic               cur_bit;
    logic [K-1:0]       window;
    logic [N_OUT-1:0]   enc;

    // The single output register can take a new symbol when it is empty or
    // its current symbol is being handed off on this same edge.
    assign slot_free = !valid_reg || out_ready;

    // During the flush the encoder is fed zeros regardless of in_bit.
    assign cur_bit   = (state_reg == TAIL) ? 1'b0 : in_bit;
    assign window    = {cur_bit, sr_reg};

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            assign enc[gi] = ^(window & GEN[gi*K +: K]);
        end
    endgenerate

    always_ff @(posedge clk_sig) begin
        if (!reset_sig) begin
            state_reg <= RUN;
            sr_reg    <= '0;
            cnt_reg   <= '0;
            sym_reg   <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            cnt_reg   <= cnt_next;
            sym_reg   <= sym_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        cnt_next   = cnt_reg;
        sym_next   = sym_reg;
        valid_next = valid_reg;
        last_next  = last_reg;

        // A completed handoff empties the slot unless a new symbol is loaded
        // below; a stalled symbol keeps its value and flags.
        if (slot_free) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
        end

        case (state_reg)
            RUN: begin
                if (in_valid && slot_free) begin
                    sym_next   = enc;
                    valid_next = 1'b1;
                    sr_next    = window[K-1:1];
                    if (in_last) begin
                        if (TAIL_EN) begin
                            state_next = TAIL;
                            cnt_next   = TAIL_INIT;
                        end else begin
                            // No flush: mark this symbol as frame end and
                            // start the next frame from the zero state.
                            last_next = 1'b1;
                            sr_next   = '0;
                        end
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    sym_next   = enc;
                    valid_next = 1'b1;
                    sr_next    = window[K-1:1];
                    cnt_next   = cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        last_next  = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign in_ready  = (state_reg == RUN) && slot_free;
    assign busy      = (state_reg == TAIL);
    assign out_sym   = sym_reg;
    assign out_valid = valid_reg;
    assign out_last  = last_reg;

endmodule

// File: tb/tb_conv_encode_param.sv
// Testbench for conv_encode_param: three parameterisations (default code,
// default code without tail, N_OUT=3/K=4 code), directed frames plus random
// frames with random backpressure, checked against a convolution model.
module tb_conv_encode_param;

    logic clk_sig = 1'b0;
    always #5 clk_sig = ~clk_sig;

    logic reset_sig, in_bit, in_valid, in_last, out_ready;
    int   sel;

    logic v0, v1, v2;
    assign v0 = in_valid && (sel == 0);
    assign v1 = in_valid && (sel == 1);
    assign v2 = in_valid && (sel == 2);

    logic [1:0] s0, s1;
    logic [2:0] s2;
    logic r0, r1, r2, ov0, ov1, ov2, ol0, ol1, ol2, b0, b1, b2;

    conv_encode_param #(.N_OUT(2), .K(3), .GEN(6'b111101), .TAIL_EN(1'b1)) dut0 (
        .clk_sig(clk_sig), .reset_sig(reset_sig), .in_bit(in_bit), .in_valid(v0),
        .in_last(in_last), .in_ready(r0), .out_sym(s0), .out_valid(ov0),
        .out_last(ol0), .out_ready(out_ready), .busy(b0));

    conv_encode_param #(.N_OUT(2), .K(3), .GEN(6'b111101), .TAIL_EN(1'b0)) dut1 (
        .clk_sig(clk_sig), .reset_sig(reset_sig), .in_bit(in_bit), .in_valid(v1),
        .in_last(in_last), .in_ready(r1), .out_sym(s1), .out_valid(ov1),
        .out_last(ol1), .out_ready(out_ready), .busy(b1));

    conv_encode_param #(.N_OUT(3), .K(4), .GEN(12'b1111_1101_1011), .TAIL_EN(1'b1)) dut2 (
        .clk_sig(clk_sig), .reset_sig(reset_sig), .in_bit(in_bit), .in_valid(v2),
        .in_last(in_last), .in_ready(r2), .out_sym(s2), .out_valid(ov2),
        .out_last(ol2), .out_ready(out_ready), .busy(b2));

    logic [2:0] obs_sym;
    logic       obs_valid, obs_last, obs_ready, obs_busy;

    always_comb begin
        obs_sym   = '0;
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        obs_ready = 1'b0;
        obs_busy  = 1'b0;
        case (sel)
            0: begin obs_sym = {1'b0, s0}; obs_valid = ov0; obs_last = ol0; obs_ready = r0; obs_busy = b0; end
            1: begin obs_sym = {1'b0, s1}; obs_valid = ov1; obs_last = ol1; obs_ready = r1; obs_busy = b1; end
            default: begin obs_sym = s2; obs_valid = ov2; obs_last = ol2; obs_ready = r2; obs_busy = b2; end
        endcase
    end

    typedef struct {
        logic [2:0] sym;
        logic       last;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int rx_cnt, last_cnt, extra_cnt, busy_cnt, exp_total;
    int mode, stall_idx, stall_left, stall_seen;
    bit prev_stall, chk_rdy1, accepted;
    logic [2:0] prev_sym;
    logic prev_last;

    int cfg_n, cfg_k;
    bit cfg_te;
    logic [11:0] cfg_g;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic set_cfg(input int c);
        sel = c;
        case (c)
            0: begin cfg_n = 2; cfg_k = 3; cfg_g = 12'b000000_111101; cfg_te = 1'b1; end
            1: begin cfg_n = 2; cfg_k = 3; cfg_g = 12'b000000_111101; cfg_te = 1'b0; end
            default: begin cfg_n = 3; cfg_k = 4; cfg_g = 12'b1111_1101_1011; cfg_te = 1'b1; end
        endcase
    endtask

    // Expected symbols by direct convolution: output j at time i is the XOR
    // over delays d of g_j(d) * u[i-d], with u zero before the frame start and
    // K-1 zeros appended when the tail is enabled.
    function automatic void build_exp(input bit bits[$]);
        bit   ext[$];
        bit   acc;
        exp_t e;
        ext = bits;
        if (cfg_te)
            for (int t = 0; t < cfg_k - 1; t++) ext.push_back(1'b0);
        for (int i = 0; i < ext.size(); i++) begin
            e.sym = '0;
            for (int j = 0; j < cfg_n; j++) begin
                acc = 1'b0;
                for (int d = 0; d < cfg_k; d++)
                    if (i - d >= 0) acc ^= cfg_g[j*cfg_k + cfg_k - 1 - d] & ext[i-d];
                e.sym[j] = acc;
            end
            e.last = (i == ext.size() - 1);
            exp_q.push_back(e);
            exp_total++;
        end
    endfunction

    task automatic begin_test();
        rx_cnt = 0; last_cnt = 0; extra_cnt = 0; busy_cnt = 0;
        stall_seen = 0; exp_total = 0; prev_stall = 1'b0;
        exp_q.delete();
    endtask

    task automatic end_test(input string name, input int frames);
        check_val({name, "_nsym"}, rx_cnt, exp_total);
        check_val({name, "_nlast"}, last_cnt, frames);
        check_val({name, "_extra"}, extra_cnt, 0);
        $display("test %s: %0d symbols, %0d frames", name, rx_cnt, last_cnt);
    endtask

    // One clock cycle: choose out_ready, observe outputs, let the edge pass.
    task automatic step();
        exp_t e;
        @(negedge clk_sig);
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (obs_valid && rx_cnt == stall_idx && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b0;
        endcase
        #1;
        accepted = in_valid && obs_ready;
        if (prev_stall) begin
            check_val("hold_valid", obs_valid, 1);
            check_val("hold_sym", obs_sym, prev_sym);
            check_val("hold_last", obs_last, prev_last);
        end
        if (obs_valid && !out_ready) begin
            check_val("stall_in_ready", obs_ready, 0);
            prev_stall = 1'b1;
            prev_sym   = obs_sym;
            prev_last  = obs_last;
        end else begin
            prev_stall = 1'b0;
        end
        if (obs_valid && out_ready) begin
            rx_cnt++;
            if (obs_last) last_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("sym", obs_sym, e.sym);
                check_val("last", obs_last, e.last);
            end else begin
                extra_cnt++;
            end
        end
        if (obs_busy) busy_cnt++;
        if (chk_rdy1) check_val("ready_high", obs_ready, 1);
        @(posedge clk_sig);
        #1;
    endtask

    task automatic drive_bit(input bit b, input bit l);
        int waited;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        waited   = 0;
        forever begin
            step();
            if (accepted) break;
            waited++;
            if (waited > 500) begin
                check_val("accept_timeout", obs_ready, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_frame(input bit bits[$], input bit gaps);
        build_exp(bits);
        for (int i = 0; i < bits.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                step();
            end
            drive_bit(bits[i], i == bits.size() - 1);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < 2000) begin
            step();
            waited++;
        end
        check_val("drain_timeout", exp_q.size(), 0);
        repeat (3) step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fr[$];
        int len;

        reset_sig = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; mode = 0; sel = 0; chk_rdy1 = 1'b0; prev_stall = 1'b0;
        stall_idx = 0; stall_left = 0;
        repeat (3) @(posedge clk_sig);
        @(negedge clk_sig);
        for (int c = 0; c < 3; c++) begin
            sel = c;
            #1;
            check_val("rst_sym", obs_sym, 0);
            check_val("rst_valid", obs_valid, 0);
            check_val("rst_last", obs_last, 0);
            check_val("rst_busy", obs_busy, 0);
            check_val("rst_in_ready", obs_ready, 1);
        end
        @(posedge clk_sig);
        #1;
        reset_sig = 1'b1;

        // Default code, free-flowing output.
        set_cfg(0); begin_test(); mode = 0;
        fr = '{1, 0, 1, 1};
        drive_frame(fr, 1'b0);
        drain();
        check_val("t1_busy_cycles", busy_cnt, cfg_k - 1);
        end_test("basic", 1);

        // Same frame with a three-cycle stall on the second symbol.
        set_cfg(0); begin_test(); mode = 2; stall_idx = 1; stall_left = 3;
        fr = '{1, 0, 1, 1};
        drive_frame(fr, 1'b0);
        drain();
        check_val("t2_stall_cycles", stall_seen, 3);
        check_val("t2_busy_cycles", busy_cnt, cfg_k - 1);
        end_test("stall", 1);

        // No tail: two back-to-back frames, input never blocked.
        set_cfg(1); begin_test(); mode = 0; chk_rdy1 = 1'b1;
        fr = '{1, 1};
        drive_frame(fr, 1'b0);
        fr = '{1};
        drive_frame(fr, 1'b0);
        chk_rdy1 = 1'b0;
        drain();
        check_val("t3_busy_cycles", busy_cnt, 0);
        end_test("notail", 2);

        // Impulse response of the N_OUT=3, K=4 code.
        set_cfg(2); begin_test(); mode = 0;
        fr = '{1};
        drive_frame(fr, 1'b0);
        drain();
        check_val("t4_busy_cycles", busy_cnt, cfg_k - 1);
        end_test("impulse", 1);

        // Reset while flushing the tail.
        set_cfg(0); begin_test(); mode = 0;
        fr = '{1, 0, 1, 1};
        drive_frame(fr, 1'b0);
        step();
        check_val("t5_busy_pre_rst", obs_busy, 1);
        reset_sig = 1'b0;
        mode = 3;
        step();
        reset_sig = 1'b1;
        prev_stall = 1'b0;
        check_val("t5_rst_valid", obs_valid, 0);
        check_val("t5_rst_sym", obs_sym, 0);
        check_val("t5_rst_last", obs_last, 0);
        check_val("t5_rst_busy", obs_busy, 0);
        check_val("t5_rst_in_ready", obs_ready, 1);
        check_val("t5_no_last", last_cnt, 0);
        begin_test(); mode = 0;
        fr = '{1};
        drive_frame(fr, 1'b0);
        drain();
        end_test("reset", 1);

        // Random frames with random gaps and random backpressure.
        for (int c = 0; c < 3; c++) begin
            set_cfg(c); begin_test(); mode = 1;
            for (int f = 0; f < 4; f++) begin
                len = (f == 0) ? 1000 : $urandom_range(1, 6);
                fr.delete();
                for (int i = 0; i < len; i++) fr.push_back(1'($urandom));
                drive_frame(fr, 1'b1);
            end
            mode = 1;
            drain();
            end_test("random", 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
